dds_wave_gen: RTL
=================

# dds_wave_gen

Parametrised direct-digital-synthesis waveform generator and successor to the fixed 64-point sine lookup. Core pieces:
- a phase accumulator driven by a frequency tuning word, plus a phase offset;
- a quarter-wave sine ROM;
- sine, square, triangle and sawtooth modes;
- glitch-free configuration updates applied at period wrap.

It feeds the DAC/PWM output stage and the audio test paths, with one sample per enabled cycle.

## Interface
- PHASE_W, 16, accumulator and tuning-word width
- QTR_AW, 4, log2 of quarter-wave points (period = 2^(QTR_AW+2) samples at full resolution)
- AMP, 1000, peak amplitude; output spans 0..2*AMP, midscale AMP; 2*AMP < 2^OUT_W required
- OUT_W, 16, sample width
- ROM_FILE, "", hex file for the quarter table; empty selects the built-in default-parameter table
- clk  in  1  clock; one clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance accumulator and launch a sample this cycle
- sync  in  1  force phase to 0 (priority over en)
- load  in  1  strobe: capture ftw_in/poff_in/mode_in into shadow registers
- ftw_in  in  PHASE_W  frequency tuning word
- poff_in  in  PHASE_W  phase offset
- mode_in  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- wave_o  out  OUT_W  unsigned sample
- valid_o  out  1  wave_o holds a new sample
- pending_o  out  1  shadow config waiting to be applied

## Operation
**Reset.** All registers clear: acc, active ftw/poff/mode, shadow, pending_o, pipeline, wave_o and valid_o are all 0.

**Accumulator.**
- sync=1: acc <= 0.
- Else en=1: acc <= acc + ftw_a (mod 2^PHASE_W).
- Wrap is the carry-out of that add when en=1.

**Phase and index.**
- p = acc + poff_a (mod 2^PHASE_W), taken from the pre-increment acc.
- t = p[PHASE_W-1 -: QTR_AW+2]; N = 2^QTR_AW; F = 4N.

**Sine.**
- Quadrant q = t[top 2]; i = t[QTR_AW-1:0].
- ROM holds N+1 entries, rom[k] = round(AMP*sin(k*pi/(2N))).
- Default table: 0,98,195,290,383,471,556,634,707,773,831,882,924,957,981,995,1000.
- Per quadrant:
  - q0: AMP+rom[i]
  - q1: AMP+rom[N-i]
  - q2: AMP-rom[i]
  - q3: AMP-rom[N-i]

**Square.** t < F/2 gives 2*AMP, else 0.

**Sawtooth.** (2*AMP*t) >> (QTR_AW+2), truncated.

**Triangle.**
- u = t if t <= F/2, else F-t.
- Output (2*AMP*u) >> (QTR_AW+1), truncated.

**Configuration.**
- load=1 writes the shadow and sets pending; a later load overwrites the shadow.
- Pending is applied (active <= shadow, pending cleared) on the same edge as any of:
  - a wrap;
  - sync;
  - active ftw_a == 0 (otherwise the block would never wrap).
- load coinciding with any apply condition: the new load values become active immediately and pending stays 0.
- The accumulator step on an apply edge uses the old ftw_a.

**Idle.** en=0 holds acc and the pipeline. The pipeline output holds its last value and valid_o drops.

## Timing
- Latency is 2 cycles: en sampled at edge n gives wave_o/valid_o at edge n+2.
  - Stage 1 registers t, q and mode, and does the registered ROM read.
  - Stage 2 does the add/subtract and mode mux into wave_o.
- valid_o = en delayed by 2 cycles. A sync cycle launches no sample.
- Throughput: one sample per cycle.
- Mode and poff changes take effect from the first sample whose stage-1 capture follows the apply edge.
- rst mid-stream: at the next edge every output is 0 and in-flight samples are discarded.

## Structure
- Shared include dds_defs.vh holds:
  - MODE_SINE=0, MODE_SQUARE=1, MODE_TRI=2, MODE_SAW=3;
  - the stage latency constant DDS_LAT=2.
- Sub-module dds_quarter_rom (params QTR_AW, AMP, ROM_FILE; ports clk, addr[QTR_AW:0], data): synchronous read.
- Arithmetic: 2*AMP*t needs log2(2*AMP)+QTR_AW+2 bits internally, then truncates to OUT_W.

## Test plan
- Sine period: defaults, load ftw=1024 then en=1 for 64 cycles → valid_o from cycle 2; samples 1000,1098,1195,…,2000 (index 16),…,0 (index 48),…,902, then repeat 1000.
- Square/saw/triangle at ftw=1024:
  - square: 2000 for samples 0-31, 0 for 32-63;
  - saw: 0,31,62,…,1968;
  - triangle: 0,62,125,…,2000 at 32, 1937 at 33, 62 at 63.
- Deferred update: running at ftw=1024, load ftw=2048 at sample 10 → pending_o=1 until the wrap after sample 63, then step 2 (1000,1195,1383,…); no sample is skipped mid-period.
- Phase offset and sync: load poff=16384 (quarter period) → first sine sample after apply is 2000. sync mid-period → next launched sample is t=poff index and pending is applied.
- ftw=0 boundary: after reset, load ftw=1024 → pending_o never asserts and the change is active next cycle. With en=0 for 5 cycles, valid_o=0 and wave_o holds.
- Reset mid-stream: rst asserted at sample 20 → wave_o=0, valid_o=0, pending_o=0 next cycle. Active ftw=0, so output restarts from 1000 only after a new load.

Source files
------------

// File: rtl/dds_wave_gen_pkg.sv
// Shared definitions for the DDS waveform generator.
//   dds_mode_e  : waveform select encoding (sine, square, triangle, sawtooth)
//   DDS_LAT     : cycles from an accepted en to the matching wave_o/valid_o
//   sine_entry  : elaboration-time quarter-wave sine value, round(amp*sin(k*pi/(2N)))
package dds_wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } dds_mode_e;

    localparam int DDS_LAT = 2;

    // Fixed-point (2^30 scale) Taylor series for sin(x), x in [0, pi/2].
    // Only ever evaluated on constants, so it folds into ROM contents.
    function automatic int sine_entry(input int k, input int qtr_aw, input int amp);
        longint x;
        longint term;
        longint sum;
        x    = (longint'(k) * 64'sd3373259426) >>> (qtr_aw + 1);
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'((longint'(amp) * sum + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/dds_wave_gen_quarter_rom.sv
// Quarter-wave sine table with a registered read port.
//   clk  : clock
//   addr : table index 0..2^QTR_AW (N+1 entries, both end points stored)
//   data : table value, valid one cycle after addr
// Table contents are computed from QTR_AW and AMP at elaboration; an external
// table file is not supported by this implementation and is rejected.
module dds_quarter_rom #(
    parameter int    QTR_AW   = 4,
    parameter int    AMP      = 1000,
    parameter string ROM_FILE = ""
) (
    input  logic                       clk,
    input  logic [QTR_AW:0]            addr,
    output logic [$clog2(AMP+1)-1:0]   data
);
    import dds_wave_gen_pkg::*;

    localparam int N  = 1 << QTR_AW;
    localparam int DW = $clog2(AMP + 1);

    logic [DW-1:0] rom_table [0:N];

    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_rom
            assign rom_table[gi] = DW'(sine_entry(gi, QTR_AW, AMP));
        end
        if (ROM_FILE != "") begin : g_no_file
            $error("dds_quarter_rom: external table files are not supported");
        end
    endgenerate

    always_ff @(posedge clk) begin
        data <= rom_table[addr];
    end

endmodule

// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis waveform generator.
//   clk, rst      : clock, synchronous active-high reset
//   en            : advance the phase accumulator and launch one sample
//   sync          : force phase to 0, launches no sample (wins over en)
//   load          : capture ftw_in/poff_in/mode_in into the shadow config
//   ftw_in        : frequency tuning word
//   poff_in       : phase offset
//   mode_in       : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   wave_o        : unsigned sample, 0..2*AMP, midscale AMP
//   valid_o       : wave_o holds a new sample (en delayed by DDS_LAT cycles)
//   pending_o     : shadow config is waiting for a wrap/sync to be applied
module dds_wave_gen #(
    parameter int    PHASE_W  = 16,
    parameter int    QTR_AW   = 4,
    parameter int    AMP      = 1000,
    parameter int    OUT_W    = 16,
    parameter string ROM_FILE = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync,
    input  logic               load,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic [PHASE_W-1:0] poff_in,
    input  logic [1:0]         mode_in,
    output logic [OUT_W-1:0]   wave_o,
    output logic               valid_o,
    output logic               pending_o
);
    import dds_wave_gen_pkg::*;

    localparam int TW = QTR_AW + 2;                  // phase bits used per sample
    localparam int N  = 1 << QTR_AW;
    localparam int F  = 4 * N;
    localparam int DW = $clog2(AMP + 1);
    localparam int MW = $clog2(2 * AMP + 1) + TW;    // room for 2*AMP*t

    // Configuration and accumulator state
    logic [PHASE_W-1:0] acc_reg;
    logic [PHASE_W-1:0] ftw_a_reg, poff_a_reg;
    dds_mode_e          mode_a_reg;
    logic [PHASE_W-1:0] ftw_s_reg, poff_s_reg;
    dds_mode_e          mode_s_reg;
    logic               pending_reg;

    logic [PHASE_W:0]   acc_sum;
    logic               wrap, apply, launch;
    logic [PHASE_W-1:0] phase;
    logic [TW-1:0]      t_cur;
    logic [QTR_AW:0]    rom_addr;

    assign acc_sum = {1'b0, acc_reg} + {1'b0, ftw_a_reg};
    assign wrap    = en & acc_sum[PHASE_W];
    // A zero tuning word never wraps, so pending config is taken at once.
    assign apply   = wrap | sync | (ftw_a_reg == '0);
    assign launch  = en & ~sync;

    assign phase = acc_reg + poff_a_reg;
    assign t_cur = phase[PHASE_W-1 -: TW];
    // Odd quadrants walk the quarter table backwards.
    assign rom_addr = t_cur[QTR_AW] ? ((QTR_AW+1)'(N) - {1'b0, t_cur[QTR_AW-1:0]})
                                    : {1'b0, t_cur[QTR_AW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            ftw_a_reg   <= '0;
            poff_a_reg  <= '0;
            mode_a_reg  <= MODE_SINE;
            ftw_s_reg   <= '0;
            poff_s_reg  <= '0;
            mode_s_reg  <= MODE_SINE;
            pending_reg <= 1'b0;
        end else begin
            if (sync)
                acc_reg <= '0;
            else if (en)
                acc_reg <= acc_sum[PHASE_W-1:0];

            if (load) begin
                ftw_s_reg  <= ftw_in;
                poff_s_reg <= poff_in;
                mode_s_reg <= dds_mode_e'(mode_in);
            end

            if (load && apply) begin
                ftw_a_reg   <= ftw_in;
                poff_a_reg  <= poff_in;
                mode_a_reg  <= dds_mode_e'(mode_in);
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end else if (apply && pending_reg) begin
                ftw_a_reg   <= ftw_s_reg;
                poff_a_reg  <= poff_s_reg;
                mode_a_reg  <= mode_s_reg;
                pending_reg <= 1'b0;
            end
        end
    end

    // Stage 1: phase index, mode, ROM read
    logic [TW-1:0]      t1_reg;
    dds_mode_e          mode1_reg;
    logic [DW-1:0]      rom_data;
    logic [DDS_LAT-1:0] vld_pipe_reg;

    dds_quarter_rom #(
        .QTR_AW   (QTR_AW),
        .AMP      (AMP),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Stage 2: reconstruction and mode mux
    logic [OUT_W-1:0] wave_reg, wave_next;
    logic [TW-1:0]    tri_u;
    logic [MW-1:0]    saw_prod, tri_prod;

    always_comb begin
        wave_next = '0;
        // Above the half point the triangle descends: F - t, done modulo 2^TW.
        tri_u     = (t1_reg <= TW'(F / 2)) ? t1_reg : (TW'(0) - t1_reg);
        saw_prod  = (MW'(2 * AMP) * MW'(t1_reg)) >> TW;
        tri_prod  = (MW'(2 * AMP) * MW'(tri_u)) >> (QTR_AW + 1);
        case (mode1_reg)
            MODE_SINE:   wave_next = t1_reg[TW-1] ? (OUT_W'(AMP) - OUT_W'(rom_data))
                                                  : (OUT_W'(AMP) + OUT_W'(rom_data));
            MODE_SQUARE: wave_next = (t1_reg < TW'(F / 2)) ? OUT_W'(2 * AMP) : '0;
            MODE_TRI:    wave_next = OUT_W'(tri_prod);
            MODE_SAW:    wave_next = OUT_W'(saw_prod);
            default:     wave_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t1_reg       <= '0;
            mode1_reg    <= MODE_SINE;
            vld_pipe_reg <= '0;
            wave_reg     <= '0;
        end else begin
            vld_pipe_reg <= {vld_pipe_reg[DDS_LAT-2:0], launch};
            if (launch) begin
                t1_reg    <= t_cur;
                mode1_reg <= mode_a_reg;
            end
            if (vld_pipe_reg[0])
                wave_reg <= wave_next;
        end
    end

    assign wave_o    = wave_reg;
    assign valid_o   = vld_pipe_reg[DDS_LAT-1];
    assign pending_o = pending_reg;

endmodule
